// File: rtl/neuron_mac.sv
// ---------------------------------------------------------------------------
// neuron_mac
// One neuron's multiply-accumulate engine, fed by Weight_Memory.
//
// Streams numWeight signed activations in over a valid/ready handshake. Each
// accepted activation fires a read of the matching weight. The engine
// accumulates activation*weight, adds a bias, and then applies ReLU, a fixed
// arithmetic right shift and saturation. It holds the result until a consumer
// takes it.
//
// Ports
//   clk        clock, all state updates on posedge
//   rst        asynchronous active-high reset
//   in_valid   activation on in_data is valid
//   in_ready   engine can accept an activation this cycle
//   in_data    signed activation
//   bias       signed bias, sampled only in the ACT cycle
//   w_ren      weight read enable (Weight_Memory.ren)
//   w_radd     weight read address (Weight_Memory.radd)
//   w_data     weight returned one cycle after w_ren (Weight_Memory.wout)
//   out_valid  out_data holds a finished result
//   out_ready  consumer takes out_data when out_valid & out_ready
//   out_data   activated result, 0 .. 2^(dataWidth-1)-1
// ---------------------------------------------------------------------------
module neuron_mac #(
    parameter int numWeight    = 128,
    parameter int addressWidth = 7,
    parameter int dataWidth    = 8,
    parameter int accWidth     = 24,
    parameter int outShift     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [dataWidth-1:0]    in_data,
    input  logic [accWidth-1:0]     bias,
    output logic                    w_ren,
    output logic [addressWidth-1:0] w_radd,
    input  logic [dataWidth-1:0]    w_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [dataWidth-1:0]    out_data
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        ACT   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [addressWidth-1:0] LAST_IDX = addressWidth'(numWeight - 1);
    localparam logic [dataWidth-1:0]    OUT_MAX  = {1'b0, {(dataWidth-1){1'b1}}};
    localparam logic signed [accWidth:0] OUT_MAX_WIDE =
        {{(accWidth-dataWidth+1){1'b0}}, OUT_MAX};

    // ReLU, rescale and saturate of acc + bias. The sum is formed one bit
    // wider than the accumulator so that it cannot overflow.
    function automatic logic [dataWidth-1:0] activate(
        input logic [accWidth-1:0] acc_val,
        input logic [accWidth-1:0] bias_val
    );
        logic signed [accWidth:0] sum_v;
        logic signed [accWidth:0] shifted_v;
        sum_v     = $signed({acc_val[accWidth-1], acc_val})
                  + $signed({bias_val[accWidth-1], bias_val});
        shifted_v = sum_v >>> outShift;
        if (sum_v[accWidth]) begin
            activate = {dataWidth{1'b0}};
        end else if (shifted_v > OUT_MAX_WIDE) begin
            activate = OUT_MAX;
        end else begin
            activate = shifted_v[dataWidth-1:0];
        end
    endfunction

    state_t                   state_r;
    state_t                   state_s;
    logic [addressWidth-1:0]  idx_r;
    logic [accWidth-1:0]      acc_r;
    logic                     mac_en_r;
    logic [dataWidth-1:0]     x_d_r;
    logic                     accept_s;
    logic signed [2*dataWidth-1:0] prod_s;
    logic [accWidth-1:0]      prod_ext_s;

    // Handshake and weight-read outputs. These are combinational so that the
    // read is issued in the same cycle as the accept. They are forced low
    // while reset is asserted.
    always_comb begin
        in_ready = (state_r == RUN) && !rst;
        accept_s = in_valid && in_ready;
        w_ren    = accept_s;
        w_radd   = idx_r;
    end

    // x_d_r was registered in the accept cycle, so it lines up with the
    // weight that comes back the next cycle.
    always_comb begin
        prod_s     = $signed(x_d_r) * $signed(w_data);
        prod_ext_s = {{(accWidth-2*dataWidth){prod_s[2*dataWidth-1]}}, prod_s};
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= RUN;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            RUN: begin
                if (accept_s && (idx_r == LAST_IDX)) begin
                    state_s = DRAIN;
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN: state_s = ACT;
            ACT:   state_s = DONE;
            DONE: begin
                if (out_ready) begin
                    state_s = RUN;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = RUN;
        endcase
    end

    // Datapath: index, activation pipeline, accumulator and the held result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r     <= {addressWidth{1'b0}};
            acc_r     <= {accWidth{1'b0}};
            mac_en_r  <= 1'b0;
            x_d_r     <= {dataWidth{1'b0}};
            out_valid <= 1'b0;
            out_data  <= {dataWidth{1'b0}};
        end else begin
            // mac_en_r is only ever set in RUN. The DONE clear therefore
            // never competes with an accumulate.
            if (mac_en_r) begin
                acc_r <= acc_r + prod_ext_s;
            end else if ((state_r == DONE) && out_ready) begin
                acc_r <= {accWidth{1'b0}};
            end else begin
                acc_r <= acc_r;
            end

            case (state_r)
                RUN: begin
                    if (accept_s) begin
                        x_d_r    <= in_data;
                        mac_en_r <= 1'b1;
                        if (idx_r == LAST_IDX) begin
                            idx_r <= {addressWidth{1'b0}};
                        end else begin
                            idx_r <= idx_r + {{(addressWidth-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        mac_en_r <= 1'b0;
                    end
                end
                DRAIN: begin
                    mac_en_r <= 1'b0;
                end
                ACT: begin
                    mac_en_r  <= 1'b0;
                    out_data  <= activate(acc_r, bias);
                    out_valid <= 1'b1;
                end
                DONE: begin
                    mac_en_r <= 1'b0;
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end else begin
                        out_valid <= out_valid;
                    end
                end
                default: begin
                    mac_en_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// ---------------------------------------------------------------------------
// tb_neuron_mac
// Directed self-checking bench for neuron_mac. It models Weight_Memory as a
// registered read array and drives activation vectors, and it checks the
// results against hand-computed values.
// ---------------------------------------------------------------------------
module tb_neuron_mac;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [23:0] bias;
    logic        w_ren;
    logic [6:0]  w_radd;
    logic [7:0]  w_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;

    logic [7:0]  wmem [128];

    int checks;
    int failures;

    neuron_mac dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .bias      (bias),
        .w_ren     (w_ren),
        .w_radd    (w_radd),
        .w_data    (w_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Weight_Memory model: registered read, data valid one cycle after ren.
    always @(posedge clk) begin
        if (w_ren) begin
            w_data <= wmem[w_radd];
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load_weights(input logic [7:0] w);
        for (int i = 0; i < 128; i++) begin
            wmem[i] = w;
        end
    endtask

    // Offer n activations of value x. With gap set, in_valid is high only on
    // every other cycle. At each cycle this counts any deviation of the read
    // port from the accept pattern.
    task automatic feed(input logic [7:0] x, input int n, input bit gap, output int err);
        int cnt;
        int cyc;
        logic [6:0] exp_addr;
        cnt = 0;
        cyc = 0;
        err = 0;
        while (cnt < n && cyc < 1000) begin
            @(negedge clk);
            in_valid = !gap || (cyc % 2 == 0);
            in_data  = x;
            #1;
            exp_addr = cnt[6:0];
            if (in_ready !== 1'b1 || w_radd !== exp_addr || w_ren !== in_valid) begin
                err++;
            end
            if (in_valid) begin
                cnt++;
            end
            cyc++;
        end
        if (cnt != n) begin
            err++;
        end
    endtask

    // Drop in_valid after the last accept. Return the number of clock edges
    // after the final accept at which out_valid was first seen high.
    task automatic wait_out(output int edges);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            n++;
        end while (out_valid !== 1'b1 && n < 50);
        edges = n - 1;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'd0;
        bias      = 24'd0;
        out_ready = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (out_data !== 8'd0) begin failures++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++;
        if (w_ren !== 1'b0) begin failures++; $display("FAIL reset_w_ren got=%b exp=0", w_ren); end
        checks++;
        if (w_radd !== 7'd0) begin failures++; $display("FAIL reset_w_radd got=%0d exp=0", w_radd); end
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
    endtask

    // Full vector with out_ready high. Checks the read pattern, the latency
    // and the result, and then the return to RUN.
    task automatic run_check(input string name, input logic [7:0] w, input logic [7:0] x,
                             input logic [23:0] b, input logic [7:0] exp);
        int err;
        int edges;
        load_weights(w);
        bias      = b;
        out_ready = 1'b1;
        feed(x, 128, 1'b0, err);
        checks++;
        if (err !== 0) begin failures++; $display("FAIL %s_read_port errors=%0d exp=0", name, err); end
        wait_out(edges);
        checks++;
        if (edges !== 2) begin failures++; $display("FAIL %s_latency got=%0d exp=2", name, edges); end
        checks++;
        if (out_data !== exp) begin failures++; $display("FAIL %s_out_data got=%0d exp=%0d", name, out_data, exp); end
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL %s_done_in_ready got=%b exp=0", name, in_ready); end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_handshake out_valid=%b in_ready=%b exp 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_basic;
        run_check("basic", 8'd1, 8'd2, 24'd0, 8'd16);
    endtask

    task automatic test_relu;
        run_check("relu", 8'hFF, 8'd1, 24'd0, 8'd0);
    endtask

    task automatic test_saturate;
        run_check("saturate", 8'd127, 8'd127, 24'd0, 8'd127);
    endtask

    task automatic test_bias;
        run_check("bias_pos", 8'd0, 8'd0, 24'd160, 8'd10);
        run_check("bias_neg", 8'd0, 8'd0, 24'hFFFFFF, 8'd0);
    endtask

    // Gapped input with a stalled consumer, then a second vector straight
    // after the handshake.
    task automatic test_back_to_back;
        int err;
        int edges;
        int hold_err;
        load_weights(8'd1);
        bias      = 24'd0;
        out_ready = 1'b0;
        feed(8'd2, 128, 1'b1, err);
        checks++;
        if (err !== 0) begin failures++; $display("FAIL stall_read_port errors=%0d exp=0", err); end
        wait_out(edges);
        checks++;
        if (edges !== 2) begin failures++; $display("FAIL stall_latency got=%0d exp=2", edges); end
        hold_err = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            #1;
            if (out_valid !== 1'b1 || out_data !== 8'd16 || in_ready !== 1'b0 || w_ren !== 1'b0) begin
                hold_err++;
            end
        end
        checks++;
        if (hold_err !== 0) begin failures++; $display("FAIL stall_hold errors=%0d exp=0", hold_err); end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b1 || w_ren !== 1'b0) begin
            failures++;
            $display("FAIL stall_pre_handshake out_valid=%b w_ren=%b exp 1/0", out_valid, w_ren);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || w_radd !== 7'd0) begin
            failures++;
            $display("FAIL stall_post_handshake out_valid=%b in_ready=%b w_radd=%0d exp 0/1/0",
                     out_valid, in_ready, w_radd);
        end
        run_check("second_vector", 8'd1, 8'd2, 24'd0, 8'd16);
    endtask

    task automatic test_mid_reset;
        int err;
        load_weights(8'd1);
        bias      = 24'd0;
        out_ready = 1'b1;
        feed(8'd2, 50, 1'b0, err);
        checks++;
        if (err !== 0) begin failures++; $display("FAIL midrst_read_port errors=%0d exp=0", err); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0 || w_ren !== 1'b0 || out_valid !== 1'b0 || w_radd !== 7'd0) begin
            failures++;
            $display("FAIL midrst_outputs in_ready=%b w_ren=%b out_valid=%b w_radd=%0d exp 0/0/0/0",
                     in_ready, w_ren, out_valid, w_radd);
        end
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        run_check("midrst_rerun", 8'd1, 8'd2, 24'd0, 8'd16);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_relu();
        test_saturate();
        test_back_to_back();
        test_bias();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
